mdu: RTL and testbench

Multiply/divide unit of the pipelined MIPS core, sitting in the E stage. It executes MULT/MULTU/DIV/DIVU over several cycles, holds the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. Its `MDU_result` travels down the E/M and M/W pipeline registers and becomes the `W_MDU_result` input of the write-back data selector.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_if.sv | 26 ++
 rtl/mdu_calc.sv | 74 +++++++
 rtl/mdu.sv | 121 ++++++++++++
 tb/tb_mdu.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_defs : shared definitions for the multiply/divide unit.
//   Holds the MDU operation encodings, which the decoder/control unit also uses,
//   and the default multi-cycle latencies.
//   No ports (package).
// -----------------------------------------------------------------------------
package mdu_defs;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        logic res;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if : E-stage <-> MDU signal bundle.
//   master : control/datapath side (drives MDU_op, A, B, Req).
//   slave  : the MDU (drives start, busy, HI, LO, MDU_result).
// -----------------------------------------------------------------------------
interface mdu_if;
    logic [3:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_result;

    modport master (
        output MDU_op, A, B, Req,
        input  start, busy, HI, LO, MDU_result
    );

    modport slave (
        input  MDU_op, A, B, Req,
        output start, busy, HI, LO, MDU_result
    );
endinterface

// File: rtl/mdu_calc.sv
// -----------------------------------------------------------------------------
// mdu_calc : combinational arithmetic core of the MDU.
//   op_i          : MDU operation (mdu_defs encodings)
//   a_i, b_i      : rs / rt operands
//   hi_o, lo_o    : HI/LO result (0 for non-arithmetic ops)
//   div_by_zero_o : divide op with b_i == 0 (result must not be committed)
// -----------------------------------------------------------------------------
module mdu_calc
    import mdu_defs::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_by_zero_o
);

    logic [63:0] prod_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] divisor_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // instead of relying on simulator/synth overflow behaviour; a zero
    // divisor is replaced by 1 to keep the divider output defined.
    always_comb begin
        prod_s        = 64'd0;
        a_mag_s       = a_i;
        b_mag_s       = b_i;
        hi_o          = 32'd0;
        lo_o          = 32'd0;
        div_by_zero_o = 1'b0;
        if (op_i == OP_DIV) begin
            a_mag_s = a_i[31] ? (32'd0 - a_i) : a_i;
            b_mag_s = b_i[31] ? (32'd0 - b_i) : b_i;
        end else begin
            a_mag_s = a_i;
            b_mag_s = b_i;
        end
        divisor_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        quo_s     = a_mag_s / divisor_s;
        rem_s     = a_mag_s % divisor_s;
        case (op_i)
            OP_MULT: begin
                prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
                hi_o   = prod_s[63:32];
                lo_o   = prod_s[31:0];
            end
            OP_MULTU: begin
                prod_s = {32'd0, a_i} * {32'd0, b_i};
                hi_o   = prod_s[63:32];
                lo_o   = prod_s[31:0];
            end
            OP_DIV: begin
                lo_o          = (a_i[31] ^ b_i[31]) ? (32'd0 - quo_s) : quo_s;
                hi_o          = a_i[31] ? (32'd0 - rem_s) : rem_s;
                div_by_zero_o = (b_i == 32'd0);
            end
            OP_DIVU: begin
                lo_o          = quo_s;
                hi_o          = rem_s;
                div_by_zero_o = (b_i == 32'd0);
            end
            default: begin
                hi_o = 32'd0;
                lo_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu : E-stage multiply/divide unit with architectural HI/LO.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mdu_if.slave -- MDU_op/A/B/Req in; start (comb), busy (reg),
//           HI, LO, MDU_result (comb: HI for MFHI, LO for MFLO, else 0) out
// The result is computed at start and parked in hi_t/lo_t; it is committed
// to HI/LO on the edge where the latency counter reaches zero.
// -----------------------------------------------------------------------------
module mdu
    import mdu_defs::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_t_q, hi_t_d;
    logic [31:0]      lo_t_q, lo_t_d;
    logic             dbz_t_q, dbz_t_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             start_s;
    logic             mt_ok_s;
    logic [31:0]      calc_hi_s;
    logic [31:0]      calc_lo_s;
    logic             calc_dbz_s;

    mdu_calc u_calc (
        .op_i          (bus.MDU_op),
        .a_i           (bus.A),
        .b_i           (bus.B),
        .hi_o          (calc_hi_s),
        .lo_o          (calc_lo_s),
        .div_by_zero_o (calc_dbz_s)
    );

    // Accept decision and MFHI/MFLO read port; start is held low during reset.
    always_comb begin
        start_s = is_muldiv(bus.MDU_op) & ~busy_q & ~bus.Req & reset;
        mt_ok_s = ~busy_q & ~bus.Req;
        case (bus.MDU_op)
            OP_MFHI: bus.MDU_result = hi_q;
            OP_MFLO: bus.MDU_result = lo_q;
            default: bus.MDU_result = 32'd0;
        endcase
    end

    // Next-state for counter, temporaries and architectural HI/LO.
    always_comb begin
        cnt_d   = cnt_q;
        hi_t_d  = hi_t_q;
        lo_t_d  = lo_t_q;
        dbz_t_d = dbz_t_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (start_s) begin
            cnt_d   = ((bus.MDU_op == OP_DIV) || (bus.MDU_op == OP_DIVU)) ? DIV_LOAD : MUL_LOAD;
            hi_t_d  = calc_hi_s;
            lo_t_d  = calc_lo_s;
            dbz_t_d = calc_dbz_s;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        // Completion and MT writes are exclusive: MT only applies when idle.
        if ((cnt_q == CNT_ONE) && !dbz_t_q) begin
            hi_d = hi_t_q;
            lo_d = lo_t_q;
        end else if (mt_ok_s && (bus.MDU_op == OP_MTHI)) begin
            hi_d = bus.A;
        end else if (mt_ok_s && (bus.MDU_op == OP_MTLO)) begin
            lo_d = bus.A;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
        busy_d = (cnt_d != CNT_ZERO);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            hi_t_q  <= 32'd0;
            lo_t_q  <= 32'd0;
            dbz_t_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_t_q  <= hi_t_d;
            lo_t_q  <= lo_t_d;
            dbz_t_q <= dbz_t_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.start = start_s;
    assign bus.busy  = busy_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu : directed self-checking bench for mdu with a result scoreboard.
// -----------------------------------------------------------------------------
module tb_mdu;
    import mdu_defs::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mdu_if u_if ();

    mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one mult/div, push its expectation, wait for busy to fall and
    // compare latency and committed HI/LO against the popped entry.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int n, input bit req_mid);
        exp_t e;
        int   cyc;
        u_if.MDU_op = op;
        u_if.A      = a;
        u_if.B      = b;
        u_if.Req    = 1'b0;
        #1;
        chk({tag, "_start"}, {31'd0, u_if.start}, 32'd1);
        e.hi = ehi;
        e.lo = elo;
        e.n  = n;
        sb.push_back(e);
        @(posedge clk);
        #1;
        u_if.MDU_op = OP_NONE;
        cyc = 0;
        while ((u_if.busy === 1'b1) && (cyc < 60)) begin
            if (req_mid) u_if.Req = (cyc == 3 || cyc == 4) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        u_if.Req = 1'b0;
        e = sb.pop_front();
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(e.n));
        chk({tag, "_hi"}, u_if.HI, e.hi);
        chk({tag, "_lo"}, u_if.LO, e.lo);
    endtask

    initial begin
        u_if.MDU_op = OP_MULT;
        u_if.A      = 32'h0000_0003;
        u_if.B      = 32'h0000_0004;
        u_if.Req    = 1'b0;
        #2;
        chk("rst_start", {31'd0, u_if.start}, 32'd0);
        chk("rst_busy",  {31'd0, u_if.busy},  32'd0);
        chk("rst_hi",    u_if.HI, 32'd0);
        chk("rst_lo",    u_if.LO, 32'd0);
        u_if.MDU_op = OP_MFHI;
        #1;
        chk("rst_result", u_if.MDU_result, 32'd0);
        u_if.MDU_op = OP_NONE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
        u_if.MDU_op = OP_MFHI;
        #1;
        chk("mfhi", u_if.MDU_result, 32'hFFFF_FFFF);
        u_if.MDU_op = OP_MFLO;
        #1;
        chk("mflo", u_if.MDU_result, 32'hFFFF_FFFE);
        u_if.MDU_op = OP_NONE;

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
        run_op("divu",  OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 1'b0);

        u_if.MDU_op = OP_MTHI;
        u_if.A      = 32'h0000_1234;
        @(posedge clk);
        #1;
        chk("mthi", u_if.HI, 32'h0000_1234);
        u_if.MDU_op = OP_MTLO;
        u_if.A      = 32'h0000_5678;
        @(posedge clk);
        #1;
        chk("mtlo", u_if.LO, 32'h0000_5678);
        chk("mtlo_hi_kept", u_if.HI, 32'h0000_1234);

        run_op("divu_by0", OP_DIVU, 32'h0000_0064, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 10, 1'b0);

        u_if.MDU_op = OP_MULT;
        u_if.A      = 32'h0000_0003;
        u_if.B      = 32'h0000_0004;
        u_if.Req    = 1'b1;
        #1;
        chk("req_start", {31'd0, u_if.start}, 32'd0);
        @(posedge clk);
        #1;
        chk("req_busy", {31'd0, u_if.busy}, 32'd0);
        u_if.MDU_op = OP_MTHI;
        u_if.A      = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("req_hi", u_if.HI, 32'h0000_1234);
        chk("req_lo", u_if.LO, 32'h0000_5678);
        u_if.Req = 1'b0;

        run_op("divu_req_mid", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10, 1'b1);

        u_if.MDU_op = OP_MULT;
        u_if.A      = 32'h0000_0003;
        u_if.B      = 32'h0000_0004;
        @(posedge clk);
        #1;
        u_if.MDU_op = OP_NONE;
        chk("mid_busy", {31'd0, u_if.busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("arst_hi", u_if.HI, 32'd0);
        chk("arst_lo", u_if.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_hi_after", u_if.HI, 32'd0);
        chk("arst_busy_after", {31'd0, u_if.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
